nibble_add_sequencer: RTL and testbench

Clocked sequencing stage that sits directly upstream of the team's unclocked, delay-modelled 4-bit adder (5-bit result {co, sum}). It accepts a wide operand pair over a valid/ready handshake and feeds the adder one nibble at a time, least significant first. After each nibble it waits a programmable settle time before sampling {co, sum}, then ripples the carry into the next nibble. It returns the assembled wide sum and final carry over a second valid/ready handshake.

---
 rtl/nibble_add_sequencer_if.sv | 27 ++
 rtl/nibble_add_sequencer.sv | 101 ++++++++++
 tb/tb_nibble_add_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_sequencer_if.sv
// Operand/result handshake bundle for nibble_add_sequencer.
// The master offers operands and consumes results; the slave is the sequencer.
interface nibble_add_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;

  modport master (
    output in_valid, in_a, in_b, in_ci, out_ready,
    input  in_ready, out_valid, out_sum, out_co
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, out_ready,
    output in_ready, out_valid, out_sum, out_co
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Drives an external unclocked 4-bit adder one nibble at a time (LSB first),
// holding each nibble's inputs for SETTLE cycles before sampling {co, sum},
// and rippling the sampled carry into the next nibble.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4,
  parameter int SETTLE  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_add_sequencer_if.slave      bus,
  output logic [3:0]                 add_a,
  output logic [3:0]                 add_b,
  output logic                       add_ci,
  input  logic [3:0]                 add_sum,
  input  logic                       add_co
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [7:0]       CNT_LOAD = 8'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       cnt_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             co_q;

  // Bit offset of the nibble currently presented to the adder.
  logic [IDX_W+1:0] nib_off;
  assign nib_off = {idx_q, 2'b00};

  // Sequencer FSM: accept operands, step through nibbles, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_ci;
            idx_q   <= '0;
            cnt_q   <= CNT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            // Adder has settled: capture this nibble and its carry.
            sum_q[nib_off +: 4] <= add_sum;
            carry_q             <= add_co;
            if (idx_q == IDX_LAST) begin
              co_q    <= add_co;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
              cnt_q <= CNT_LOAD;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Adder inputs come straight from registers so they stay put for the whole
  // settle window; they are parked at zero outside WAIT.
  always_comb begin
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_ci = 1'b0;
    if (state_q == S_WAIT) begin
      add_a  = a_q[nib_off +: 4];
      add_b  = b_q[nib_off +: 4];
      add_ci = carry_q;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_co    = co_q;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer with a 12-unit transport-delay
// adder model and a 10-unit clock. A second instance with SETTLE = 1 shows
// what happens when the settle window is shorter than the adder delay.
module tb_nibble_add_sequencer;
  localparam int NIB = 4;
  localparam int ST  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_add_sequencer_if #(.NIBBLES(NIB)) bus  ();
  nibble_add_sequencer_if #(.NIBBLES(NIB)) bus1 ();

  logic [3:0] add_a, add_b, add_sum;
  logic       add_ci, add_co;
  logic [3:0] add_a1, add_b1, add_sum1;
  logic       add_ci1, add_co1;

  nibble_add_sequencer #(.NIBBLES(NIB), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co)
  );

  nibble_add_sequencer #(.NIBBLES(NIB), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
    .add_sum(add_sum1), .add_co(add_co1)
  );

  // Ideal 4-bit adders with 12 units of transport delay.
  logic [4:0] res0 = 5'd0;
  logic [4:0] res1 = 5'd0;
  always @(add_a or add_b or add_ci)
    res0 <= #12 {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};
  always @(add_a1 or add_b1 or add_ci1)
    res1 <= #12 {1'b0, add_a1} + {1'b0, add_b1} + {4'd0, add_ci1};
  assign {add_co, add_sum}   = res0;
  assign {add_co1, add_sum1} = res1;

  int n_chk  = 0;
  int n_fail = 0;
  int stab_err = 0;
  bit track = 1'b0;
  logic       ci_log [NIB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operand pair, follow it to out_valid, optionally acknowledge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input bit ack, output logic [15:0] s, output logic co,
                       output int lat);
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_ci = ci; bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      if (c / ST < NIB) begin
        ci_log[c / ST] = add_ci;
        if (track && (add_a !== a[4*(c/ST) +: 4] || add_b !== b[4*(c/ST) +: 4]))
          stab_err++;
      end
    end
    s  = bus.out_sum;
    co = bus.out_co;
    if (ack) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s, ra, rb;
    logic        co, rc;
    logic [16:0] ref_v;
    int          lat;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_ci = 1'b0; bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_ci = 1'b0; bus1.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_co", bus.out_co, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_ci", add_ci, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    // Basic add and latency
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1, s, co, lat);
    chk("basic_sum", s, 16'h5555);
    chk("basic_co", co, 0);
    chk("basic_lat", lat, 8);

    // Carry ripple
    do_op(16'h0FFF, 16'h0001, 1'b0, 1'b1, s, co, lat);
    chk("ripple_sum", s, 16'h1000);
    chk("ripple_co", co, 0);
    chk("ripple_ci0", ci_log[0], 0);
    chk("ripple_ci1", ci_log[1], 1);
    chk("ripple_ci2", ci_log[2], 1);
    chk("ripple_ci3", ci_log[3], 1);

    // Full scale
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, s, co, lat);
    chk("full_sum", s, 16'hFFFF);
    chk("full_co", co, 1);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b1, s, co, lat);
    chk("top_sum", s, 16'h0000);
    chk("top_co", co, 1);

    // Handshake: hold off the consumer while another operand is offered
    do_op(16'h0A0B, 16'h0102, 1'b0, 1'b0, s, co, lat);
    chk("hs_sum", s, 16'h0B0D);
    bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_ci = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hs_hold_valid", bus.out_valid, 1);
      chk("hs_hold_ready", bus.in_ready, 0);
      chk("hs_hold_sum", bus.out_sum, 16'h0B0D);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("hs_valid_drop", bus.out_valid, 0);
    chk("hs_ready_back", bus.in_ready, 1);
    do_op(16'h1111, 16'h2222, 1'b0, 1'b1, s, co, lat);
    chk("hs_next_sum", s, 16'h3333);
    chk("hs_next_co", co, 0);

    // Too short a settle window samples the previous nibble's result
    @(negedge clk);
    bus1.in_a = 16'h1234; bus1.in_b = 16'h4321; bus1.in_ci = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus1.out_valid) begin
        lat = c;
        break;
      end
    end
    chk("s1_lat", lat, 4);
    chk("s1_stale_sum", bus1.out_sum, 16'h5550);
    chk("s1_stale_co", bus1.out_co, 0);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.out_ready = 1'b0;

    // Random operands against a reference sum, with input stability tracking
    track = 1'b1;
    stab_err = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_op(ra, rb, rc, 1'b1, s, co, lat);
      chk("rnd_result", {co, s}, ref_v);
    end
    track = 1'b0;
    chk("rnd_add_stable", stab_err, 0);

    // Reset in the third WAIT cycle
    @(negedge clk);
    bus.in_a = 16'h1234; bus.in_b = 16'h4321; bus.in_ci = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_out_sum", bus.out_sum, 0);
    chk("mid_rst_out_co", bus.out_co, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, s, co, lat);
    chk("post_rst_sum", s, 16'h0100);
    chk("post_rst_co", co, 0);
    chk("post_rst_lat", lat, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
